vec_stream_tx: RTL and testbench

- Source side of the layer streaming interface: buffers one N-element signed vector and transmits it element by element on a valid/ready master port.
- Sits in front of a layer block: drives that layer's s_valid/data_in and consumes its s_ready.
- Host loads the buffer through a simple write port, then pulses start; the block streams elements 0..N-1 in order at up to one per cycle.

---
 rtl/vec_stream_pkg.sv | 14 +
 rtl/vec_stream_tx_mem.sv | 25 ++
 rtl/vec_stream_tx.sv | 193 +++++++++++++++++++
 tb/tb_vec_stream_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vec_stream_pkg.sv
// Shared types and helpers for the vector stream transmitter.
package vec_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } tx_state_t;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_stream_tx_mem.sv
// N x T single-port vector buffer: write on we_i, registered read (1-cycle latency).
// Contents have no reset so they survive a block reset.
module vec_stream_tx_mem #(
  parameter int WIDTH   = 16,
  parameter int SIZE    = 8,
  parameter int LOGSIZE = 3
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [LOGSIZE-1:0] addr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  output logic [WIDTH-1:0]   rdata_o
);

  logic [WIDTH-1:0] mem_q [SIZE];

  // Read-before-write single port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/vec_stream_tx.sv
// Buffers one N-element signed vector and streams it on a valid/ready master port.
// Optional macro VEC_STREAM_TX_LAST_EN adds the m_last output.
module vec_stream_tx
  import vec_stream_pkg::*;
#(
  parameter int N = 8,
  parameter int T = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_addr,
  input  logic [T-1:0]         wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [T-1:0]         data_out
`ifdef VEC_STREAM_TX_LAST_EN
  ,
  output logic                 m_last
`endif
);

  localparam int AW = addr_width(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1'b1);
  localparam logic [AW:0]   N_EXT    = (AW + 1)'(N);

  tx_state_t      state_q, state_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic           rd_all_q, rd_all_d;
  logic           inflight_q, inflight_d;
  logic           out_v_q, out_v_d;
  logic [T-1:0]   data_q, data_d;
  logic           skid_v_q, skid_v_d;
  logic [T-1:0]   skid_q, skid_d;
  logic [AW-1:0]  tx_cnt_q, tx_cnt_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           last_q, last_d;

  logic           pop_s;
  logic [1:0]     occ_s;
  logic           mem_we_s;
  logic [AW-1:0]  mem_addr_s;
  logic [T-1:0]   rdata_s;

  vec_stream_tx_mem #(
    .WIDTH  (T),
    .SIZE   (N),
    .LOGSIZE(AW)
  ) u_buf (
    .clk    (clk),
    .we_i   (mem_we_s),
    .addr_i (mem_addr_s),
    .wdata_i(wr_data),
    .rdata_o(rdata_s)
  );

  // Next-state: FSM, prefetch pipeline (output reg + skid + one read in flight)
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_all_d   = rd_all_q;
    inflight_d = 1'b0;
    out_v_d    = out_v_q;
    data_d     = data_q;
    skid_v_d   = skid_v_q;
    skid_d     = skid_q;
    tx_cnt_d   = tx_cnt_q;
    done_d     = 1'b0;
    mem_we_s   = 1'b0;
    mem_addr_s = rd_ptr_q;
    pop_s      = out_v_q & m_ready;
    // Elements held or arriving next cycle, before any new read is issued
    occ_s      = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, inflight_q} - {1'b0, pop_s};

    case (state_q)
      IDLE: begin
        mem_addr_s = wr_addr;
        mem_we_s   = wr_en & ({1'b0, wr_addr} < N_EXT);
        if (start) begin
          state_d  = FETCH;
          tx_cnt_d = {AW{1'b0}};
        end else begin
          state_d  = IDLE;
        end
      end

      FETCH: begin
        inflight_d = 1'b1;
        rd_all_d   = (rd_ptr_q == LAST_IDX);
        rd_ptr_d   = (rd_ptr_q == LAST_IDX) ? {AW{1'b0}} : rd_ptr_q + IDX_ONE;
        state_d    = SEND;
      end

      SEND: begin
        if (!out_v_q || pop_s) begin
          if (skid_v_q) begin
            data_d   = skid_q;
            out_v_d  = 1'b1;
            skid_v_d = inflight_q;
            skid_d   = inflight_q ? rdata_s : skid_q;
          end else if (inflight_q) begin
            data_d  = rdata_s;
            out_v_d = 1'b1;
          end else begin
            out_v_d = 1'b0;
          end
        end else if (inflight_q) begin
          skid_v_d = 1'b1;
          skid_d   = rdata_s;
        end else begin
          skid_v_d = skid_v_q;
        end

        if (!rd_all_q && (occ_s < 2'd2)) begin
          inflight_d = 1'b1;
          rd_all_d   = (rd_ptr_q == LAST_IDX);
          rd_ptr_d   = (rd_ptr_q == LAST_IDX) ? {AW{1'b0}} : rd_ptr_q + IDX_ONE;
        end else begin
          inflight_d = 1'b0;
        end

        if (pop_s && (tx_cnt_q == LAST_IDX)) begin
          state_d  = IDLE;
          out_v_d  = 1'b0;
          skid_v_d = 1'b0;
          done_d   = 1'b1;
          tx_cnt_d = {AW{1'b0}};
        end else if (pop_s) begin
          tx_cnt_d = tx_cnt_q + IDX_ONE;
        end else begin
          tx_cnt_d = tx_cnt_q;
        end
      end

      default: begin
        state_d = IDLE;
        out_v_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
    last_d = out_v_d & (tx_cnt_d == LAST_IDX);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= {AW{1'b0}};
      rd_all_q   <= 1'b0;
      inflight_q <= 1'b0;
      out_v_q    <= 1'b0;
      data_q     <= {T{1'b0}};
      skid_v_q   <= 1'b0;
      skid_q     <= {T{1'b0}};
      tx_cnt_q   <= {AW{1'b0}};
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_all_q   <= rd_all_d;
      inflight_q <= inflight_d;
      out_v_q    <= out_v_d;
      data_q     <= data_d;
      skid_v_q   <= skid_v_d;
      skid_q     <= skid_d;
      tx_cnt_q   <= tx_cnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      last_q     <= last_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign m_valid  = out_v_q;
  assign data_out = data_q;

`ifdef VEC_STREAM_TX_LAST_EN
  assign m_last = last_q;
`else
  logic unused_last_s;
  assign unused_last_s = last_q;
`endif

endmodule

// File: tb/tb_vec_stream_tx.sv
// Directed, table-driven bench for vec_stream_tx (N=8, T=16).
module tb_vec_stream_tx;

  localparam int N = 8;
  localparam int T = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 wr_en;
  logic [$clog2(N)-1:0] wr_addr;
  logic [T-1:0]         wr_data;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 m_valid;
  logic                 m_ready;
  logic [T-1:0]         data_out;
`ifdef VEC_STREAM_TX_LAST_EN
  logic                 m_last;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic signed [T-1:0] exp_vec [N];
  logic                rdy_pat [6];

  typedef struct {
    logic              rdy;
    logic              v;
    logic signed [T-1:0] d;
    logic              chk_d;
    logic              b;
    logic              dn;
    logic              last;
  } vec_t;
  vec_t tbl [11];

  vec_stream_tx #(.N(N), .T(T)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .data_out(data_out)
`ifdef VEC_STREAM_TX_LAST_EN
    ,
    .m_last  (m_last)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  // Start a transmission and follow it to done, checking order, stalls and latency
  task automatic run_stream(input bit toggle, input bit disturb, input string tag);
    int   got;
    int   cyc;
    int   first_v;
    bit   seen_done;
    logic prev_stall;
    logic [T-1:0] prev_data;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    chk({tag, " busy_rise"}, 32'(busy), 32'd1);
    got = 0; cyc = 0; first_v = -1; seen_done = 1'b0; prev_stall = 1'b0; prev_data = '0;
    while (!seen_done && cyc < 200) begin
      m_ready = toggle ? rdy_pat[cyc % 6] : 1'b1;
      if (disturb && cyc == 4) begin
        wr_en = 1'b1; wr_addr = '0; wr_data = 16'sd999; start = 1'b1;
      end else begin
        wr_en = 1'b0; start = 1'b0;
      end
      chk({tag, " busy"}, 32'(busy), 32'd1);
      if (m_valid && first_v < 0) first_v = cyc;
      if (prev_stall) begin
        chk({tag, " stall_valid"}, 32'(m_valid), 32'd1);
        chk({tag, " stall_data"}, 32'(data_out), 32'(prev_data));
      end
`ifdef VEC_STREAM_TX_LAST_EN
      chk({tag, " m_last"}, 32'(m_last), 32'(m_valid && got == N - 1));
`endif
      if (m_valid && m_ready) begin
        if (got < N) chk({tag, " element"}, 32'($signed(data_out)), 32'(exp_vec[got]));
        got++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = data_out;
      tick();
      cyc++;
      if (done) begin
        seen_done = 1'b1;
        chk({tag, " count"}, 32'(got), 32'(N));
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, " valid_at_done"}, 32'(m_valid), 32'd0);
      end
    end
    wr_en = 1'b0; start = 1'b0;
    chk({tag, " done_seen"}, 32'(seen_done), 32'd1);
    chk({tag, " latency"}, 32'(first_v), 32'd2);
  endtask

  initial begin
    exp_vec[0] = 16'sd10;  exp_vec[1] = -16'sd20; exp_vec[2] = 16'sd30;  exp_vec[3] = -16'sd40;
    exp_vec[4] = 16'sd50;  exp_vec[5] = -16'sd60; exp_vec[6] = 16'sd70;  exp_vec[7] = -16'sd80;
    rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0;
    rdy_pat[3] = 1'b1; rdy_pat[4] = 1'b0; rdy_pat[5] = 1'b1;

    // Continuous-ready table: entry i is sampled after edge k+1+i (start sampled at k)
    tbl[0] = '{rdy: 1'b1, v: 1'b0, d: 16'sd0, chk_d: 1'b0, b: 1'b1, dn: 1'b0, last: 1'b0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{rdy: 1'b1, v: 1'b1, d: exp_vec[i-1], chk_d: 1'b1, b: 1'b1, dn: 1'b0, last: (i == 8)};
    tbl[9]  = '{rdy: 1'b1, v: 1'b0, d: -16'sd80, chk_d: 1'b1, b: 1'b0, dn: 1'b1, last: 1'b0};
    tbl[10] = '{rdy: 1'b1, v: 1'b0, d: -16'sd80, chk_d: 1'b1, b: 1'b0, dn: 1'b0, last: 1'b0};

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; m_ready = 1'b0;
    tick(); tick();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset m_valid", 32'(m_valid), 32'd0);
    chk("reset data_out", 32'(data_out), 32'd0);
`ifdef VEC_STREAM_TX_LAST_EN
    chk("reset m_last", 32'(m_last), 32'd0);
`endif
    reset = 1'b0;

    for (int i = 0; i < N; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = exp_vec[i];
      tick();
    end
    wr_en = 1'b0;

    start = 1'b1; m_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("tbl busy_k", 32'(busy), 32'd1);
    chk("tbl valid_k", 32'(m_valid), 32'd0);
    for (int i = 0; i < 11; i++) begin
      m_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl[%0d] m_valid", i), 32'(m_valid), 32'(tbl[i].v));
      chk($sformatf("tbl[%0d] busy", i), 32'(busy), 32'(tbl[i].b));
      chk($sformatf("tbl[%0d] done", i), 32'(done), 32'(tbl[i].dn));
      if (tbl[i].chk_d)
        chk($sformatf("tbl[%0d] data_out", i), 32'($signed(data_out)), 32'(tbl[i].d));
`ifdef VEC_STREAM_TX_LAST_EN
      chk($sformatf("tbl[%0d] m_last", i), 32'(m_last), 32'(tbl[i].last));
`endif
    end

    run_stream(1'b1, 1'b0, "toggle");
    chk("b2b done_before_start", 32'(done), 32'd1);
    run_stream(1'b0, 1'b0, "b2b");

    // Reset applied at the edge of the 4th handshake
    m_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_mid elem3", 32'($signed(data_out)), 32'(-16'sd40));
    chk("rst_mid valid", 32'(m_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid m_valid", 32'(m_valid), 32'd0);
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid done", 32'(done), 32'd0);
    tick();
    chk("rst_mid no_done", 32'(done), 32'd0);
    run_stream(1'b0, 1'b0, "after_rst");

    run_stream(1'b0, 1'b1, "disturb");
    for (int i = 0; i < 3; i++) tick();
    chk("no_extra busy", 32'(busy), 32'd0);
    chk("no_extra valid", 32'(m_valid), 32'd0);
    run_stream(1'b0, 1'b0, "retained");

    exp_vec[7] = 16'sd123;
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'sd123;
    run_stream(1'b0, 1'b0, "wr_start");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
